// File: rtl/parity_pkg.sv
// Shared state and mode encodings for the parity word engine.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// Datapath for one word: bit counter, running XOR and MSB-first shift register.
// Next values are exported so the completing bit can be captured on its own edge.
module parity_accum #(
    parameter int WORD_BITS = 4,
    parameter int CNT_BITS  = $clog2(WORD_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 data_i,
    output logic [CNT_BITS-1:0]  count_o,
    output logic                 acc_o,
    output logic [WORD_BITS-1:0] shreg_o,
    output logic                 accNext_o,
    output logic [WORD_BITS-1:0] shregNext_o
);

    logic [CNT_BITS-1:0]  count_q;
    logic                 acc_q;
    logic [WORD_BITS-1:0] shreg_q;

    assign accNext_o   = acc_q ^ data_i;
    assign shregNext_o = (shreg_q << 1) | WORD_BITS'(data_i);

    // Clear beats enable so a word's final bit leaves the datapath empty for the next word.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            count_q <= '0;
            acc_q   <= 1'b0;
            shreg_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
            acc_q   <= accNext_o;
            shreg_q <= shregNext_o;
        end
    end

    assign count_o = count_q;
    assign acc_o   = acc_q;
    assign shreg_o = shreg_q;

endmodule

// File: rtl/parity_word_engine.sv
// Frames a serial bit stream into words and generates or checks their parity.
// Define PARITY_ERR_COUNT_EN to add the saturating parity-error counter.
module parity_word_engine
    import parity_pkg::*;
#(
    parameter int WORD_BITS = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    input  logic                 wr_en,
    input  logic                 check_mode,
    input  logic                 even_parity,
    input  logic                 abort,
    output logic                 busy,
    output logic                 valid,
    output logic [WORD_BITS-1:0] word_out,
    output logic                 parity_bit,
    output logic                 parity_err,
    output logic [CNT_W-1:0]     err_count
);

    localparam int CW = $clog2(WORD_BITS + 1);

    state_e               state_q;
    logic                 mode_q;
    logic                 even_q;
    logic                 busy_q;
    logic                 valid_q;
    logic [WORD_BITS-1:0] word_q;
    logic                 parity_q;
    logic                 err_q;

    logic [CW-1:0]        count;
    logic                 acc;
    logic [WORD_BITS-1:0] shreg;
    logic                 accNext;
    logic [WORD_BITS-1:0] shregNext;

    logic modeEff;
    logic evenEff;
    logic dataBit;
    logic lastData;
    logic parBit;
    logic parRef;
    logic parErr;
    logic accClear;

    // On the first bit of a word the live inputs stand in for the not-yet-latched mode.
    assign modeEff  = (state_q == ST_IDLE) ? check_mode  : mode_q;
    assign evenEff  = (state_q == ST_IDLE) ? even_parity : even_q;
    assign dataBit  = wr_en && !abort && (state_q != ST_PAR);
    assign lastData = dataBit && (count == CW'(WORD_BITS - 1));
    assign parBit   = wr_en && !abort && (state_q == ST_PAR);
    assign parRef   = acc ^ even_q;
    assign parErr   = parBit && (data_in != parRef);
    assign accClear = abort || parBit || (lastData && modeEff == MODE_GEN);

    parity_accum #(
        .WORD_BITS (WORD_BITS),
        .CNT_BITS  (CW)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (accClear),
        .enable_i    (dataBit),
        .data_i      (data_in),
        .count_o     (count),
        .acc_o       (acc),
        .shreg_o     (shreg),
        .accNext_o   (accNext),
        .shregNext_o (shregNext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_GEN;
            even_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            word_q   <= '0;
            parity_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else if (wr_en) begin
                case (state_q)
                    ST_IDLE, ST_DATA: begin
                        if (state_q == ST_IDLE) begin
                            mode_q <= check_mode;
                            even_q <= even_parity;
                        end
                        if (lastData && modeEff == MODE_GEN) begin
                            state_q  <= ST_IDLE;
                            busy_q   <= 1'b0;
                            valid_q  <= 1'b1;
                            word_q   <= shregNext;
                            parity_q <= accNext ^ evenEff;
                            err_q    <= 1'b0;
                        end else if (lastData) begin
                            state_q <= ST_PAR;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DATA;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_PAR: begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        word_q   <= shreg;
                        parity_q <= parRef;
                        err_q    <= parErr;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign word_out   = word_q;
    assign parity_bit = parity_q;
    assign parity_err = err_q;

`ifdef PARITY_ERR_COUNT_EN
    logic [CNT_W-1:0] errCount_q;

    // Survives abort on purpose; only reset clears the error history.
    always_ff @(posedge clk) begin
        if (rst) begin
            errCount_q <= '0;
        end else if (parErr && errCount_q != '1) begin
            errCount_q <= errCount_q + 1'b1;
        end
    end

    assign err_count = errCount_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_word_engine.sv
// Scoreboard bench for parity_word_engine: directed scenarios plus random traffic.
// Honours PARITY_ERR_COUNT_EN the same way the design does.
module tb_parity_word_engine;

    localparam int WB    = 4;
    localparam int CNTW  = 2;

    typedef struct {
        logic [WB-1:0]   word;
        logic            par;
        logic            err;
        logic [CNTW-1:0] cnt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            data_in = 1'b0;
    logic            wr_en = 1'b0;
    logic            check_mode = 1'b0;
    logic            even_parity = 1'b0;
    logic            abort = 1'b0;
    logic            busy;
    logic            valid;
    logic [WB-1:0]   word_out;
    logic            parity_bit;
    logic            parity_err;
    logic [CNTW-1:0] err_count;

    int   total = 0;
    int   bad   = 0;
    bit   monOn = 0;

    exp_t sb[$];
    bit   expValid = 0;
    bit   expBusy  = 0;
    bit   rstSeen  = 0;

    parity_word_engine #(.WORD_BITS(WB), .CNT_W(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .check_mode  (check_mode),
        .even_parity (even_parity),
        .abort       (abort),
        .busy        (busy),
        .valid       (valid),
        .word_out    (word_out),
        .parity_bit  (parity_bit),
        .parity_err  (parity_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic d, input logic w, input logic cm,
                                 input logic ev, input logic ab, input logic r);
        @(negedge clk);
        data_in     = d;
        wr_en       = w;
        check_mode  = cm;
        even_parity = ev;
        abort       = ab;
        rst         = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sendWord(input logic [WB-1:0] w, input logic cm, input logic ev, input int gap);
        for (int i = WB - 1; i >= 0; i--) begin
            applyStimulus(w[i], 1'b1, cm, ev, 1'b0, 1'b0);
            idle(gap);
        end
    endtask

    // Reference model: collects accepted bits as a list and evaluates each word whole.
    initial begin : model
        bit              bits[$];
        bit              inPar;
        bit              mMode;
        bit              mEven;
        int              errCnt;
        exp_t            e;
        int              ones;
        inPar  = 0;
        mMode  = 0;
        mEven  = 0;
        errCnt = 0;
        forever begin
            @(posedge clk);
            expValid = 0;
            rstSeen  = 0;
            if (rst) begin
                bits.delete();
                inPar   = 0;
                errCnt  = 0;
                rstSeen = 1;
            end else if (abort) begin
                bits.delete();
                inPar = 0;
            end else if (wr_en) begin
                if (!inPar) begin
                    if (bits.size() == 0) begin
                        mMode = check_mode;
                        mEven = even_parity;
                    end
                    bits.push_back(data_in);
                end
                if (inPar || (bits.size() == WB && !mMode)) begin
                    e.word = '0;
                    ones = 0;
                    foreach (bits[i]) begin
                        e.word = WB'(e.word * 2 + int'(bits[i]));
                        ones += int'(bits[i]);
                    end
                    e.par = logic'(ones % 2) ^ mEven;
                    e.err = inPar && (data_in != e.par);
`ifdef PARITY_ERR_COUNT_EN
                    if (e.err && errCnt < (1 << CNTW) - 1) errCnt++;
`endif
                    e.cnt = CNTW'(errCnt);
                    sb.push_back(e);
                    expValid = 1;
                    bits.delete();
                    inPar = 0;
                end else if (bits.size() == WB) begin
                    inPar = 1;
                end
            end
            expBusy = (bits.size() > 0) || inPar;
        end
    end

    // Monitor: pops on every valid and checks that outputs hold between valids.
    initial begin : monitor
        exp_t            e;
        logic [WB-1:0]   hWord;
        logic            hPar;
        logic            hErr;
        logic [CNTW-1:0] hCnt;
        hWord = '0;
        hPar  = 0;
        hErr  = 0;
        hCnt  = '0;
        forever begin
            @(negedge clk);
            if (monOn) begin
                if (rstSeen) begin
                    hWord = '0;
                    hPar  = 0;
                    hErr  = 0;
                    hCnt  = '0;
                end
                checkOutput("valid", 32'(valid), 32'(expValid));
                checkOutput("busy", 32'(busy), 32'(expBusy));
                if (valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_valid", 32'(valid), 32'd0);
                    end else begin
                        e     = sb.pop_front();
                        hWord = e.word;
                        hPar  = e.par;
                        hErr  = e.err;
                        hCnt  = e.cnt;
                    end
                end
                checkOutput("word_out", 32'(word_out), 32'(hWord));
                checkOutput("parity_bit", 32'(parity_bit), 32'(hPar));
                checkOutput("parity_err", 32'(parity_err), 32'(hErr));
                checkOutput("err_count", 32'(err_count), 32'(hCnt));
            end
        end
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        monOn = 1;
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_word", 32'(word_out), 32'd0);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;

        sendWord(4'b1001, 1'b0, 1'b0, 0);
        idle(2);
        sendWord(4'b1001, 1'b0, 1'b1, 2);
        idle(2);

        sendWord(4'b1001, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        sendWord(4'b1001, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        sendWord(4'b0111, 1'b0, 1'b0, 0);
        idle(2);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sendWord(4'b1100, 1'b0, 1'b0, 0);
        idle(2);

        for (int k = 0; k < 5; k++) begin
            sendWord(4'b1001, 1'b1, 1'b0, 0);
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle(2);

        for (int c = 0; c < 600; c++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 149) == 0));
        end
        idle(4);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
